// File: rtl/button_reader.sv
// button_reader: debounced push-button reader with press, release and
// long-press strobes plus an 8-bit wrapping press counter.
// Ports: clk, reset_n (sync, active-low), btn_n (raw, active-low pin),
//   btn_level (1 = pressed), press_pulse, release_pulse, long_pulse,
//   press_count[7:0].
// Optional: define BUTTON_READER_REPEAT_EN for auto-repeat while held.
module button_reader #(
   parameter int DEBOUNCE_CYCLES   = 240_000,
   parameter int LONG_PRESS_CYCLES = 24_000_000,
   parameter int REPEAT_CYCLES     = 6_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_n,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic [7:0] press_count
);

   typedef enum logic [2:0] {
      IDLE,
      DEB_PRESS,
      PRESSED,
      HELD,
      DEB_RELEASE
   } state_t;

   localparam logic [24:0] DEB_LAST  = 25'(DEBOUNCE_CYCLES - 1);
   localparam logic [24:0] LONG_LAST = 25'(LONG_PRESS_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [24:0] deb_cnt;
   logic [24:0] deb_nxt;
   logic [24:0] hold_cnt;
   logic [24:0] hold_nxt;
   logic        long_fired;
   logic        fired_nxt;
   logic        sync_1;
   logic        sync_n;

   logic        level_d;
   logic        press_d;
   logic        release_d;
   logic        long_d;

`ifdef BUTTON_READER_REPEAT_EN
   localparam logic [24:0] REP_LAST = 25'(REPEAT_CYCLES - 1);
   logic [24:0] rep_cnt;
   logic [24:0] rep_nxt;
`endif

   // Two-flop synchronizer; resets to the released level.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_1 <= 1'b1;
         sync_n <= 1'b1;
      end else begin
         sync_1 <= btn_n;
         sync_n <= sync_1;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         deb_cnt    <= '0;
         hold_cnt   <= '0;
         long_fired <= 1'b0;
`ifdef BUTTON_READER_REPEAT_EN
         rep_cnt    <= '0;
`endif
      end else begin
         state      <= state_nxt;
         deb_cnt    <= deb_nxt;
         hold_cnt   <= hold_nxt;
         long_fired <= fired_nxt;
`ifdef BUTTON_READER_REPEAT_EN
         rep_cnt    <= rep_nxt;
`endif
      end
   end

   // Next-state and counter logic. A release seen in PRESSED or HELD
   // wins over any threshold reached in the same cycle.
   always_comb begin
      state_nxt = state;
      deb_nxt   = deb_cnt;
      hold_nxt  = hold_cnt;
      fired_nxt = long_fired;
`ifdef BUTTON_READER_REPEAT_EN
      rep_nxt   = rep_cnt;
`endif
      unique case (state)
         IDLE: begin
            if (!sync_n) begin
               state_nxt = DEB_PRESS;
               deb_nxt   = '0;
            end
         end
         DEB_PRESS: begin
            if (sync_n) begin
               state_nxt = IDLE;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = PRESSED;
               hold_nxt  = '0;
               fired_nxt = 1'b0;
            end else begin
               deb_nxt = deb_cnt + 25'd1;
            end
         end
         PRESSED: begin
            if (sync_n) begin
               state_nxt = DEB_RELEASE;
               deb_nxt   = '0;
            end else if (hold_cnt == LONG_LAST) begin
               state_nxt = HELD;
               fired_nxt = 1'b1;
`ifdef BUTTON_READER_REPEAT_EN
               rep_nxt   = '0;
`endif
            end else begin
               hold_nxt = hold_cnt + 25'd1;
            end
         end
         HELD: begin
            if (sync_n) begin
               state_nxt = DEB_RELEASE;
               deb_nxt   = '0;
            end else begin
`ifdef BUTTON_READER_REPEAT_EN
               if (rep_cnt == REP_LAST) begin
                  rep_nxt = '0;
               end else begin
                  rep_nxt = rep_cnt + 25'd1;
               end
`endif
            end
         end
         DEB_RELEASE: begin
            // A glitch back to low resumes the press where it left off.
            if (!sync_n) begin
               state_nxt = long_fired ? HELD : PRESSED;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = IDLE;
            end else begin
               deb_nxt = deb_cnt + 25'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode: next values of the registered outputs.
   always_comb begin
      level_d   = btn_level;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      unique case (state)
         DEB_PRESS: begin
            if (!sync_n && deb_cnt == DEB_LAST) begin
               press_d = 1'b1;
               level_d = 1'b1;
            end
         end
         PRESSED: begin
            long_d = !sync_n && hold_cnt == LONG_LAST;
         end
         HELD: begin
`ifdef BUTTON_READER_REPEAT_EN
            press_d = !sync_n && rep_cnt == REP_LAST;
`endif
         end
         DEB_RELEASE: begin
            if (sync_n && deb_cnt == DEB_LAST) begin
               release_d = 1'b1;
               level_d   = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         press_count   <= '0;
      end else begin
         btn_level     <= level_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
         long_pulse    <= long_d;
         press_count   <= press_count + {7'd0, press_d};
      end
   end

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: directed stimulus for button_reader with a run-length
// behavioural model checked every cycle, plus literal latency checks.
module tb_button_reader;

   localparam int DEB  = 4;
   localparam int LONG = 16;
   localparam int REP  = 8;

   logic       clk;
   logic       reset_n;
   logic       btn_n;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic [7:0] press_count;

   int cmp_cnt;
   int bad_cnt;
   int ecnt;

   int press_q[$];
   int rel_q[$];
   int long_q[$];

   // Model state: debounced level, length of the current run of
   // synchronized samples disagreeing with it, accumulated hold time.
   int m_s1, m_s2;
   int m_level, m_run, m_hold, m_fired, m_rep, m_count;
   int m_press, m_rel, m_long;

   button_reader #(
      .DEBOUNCE_CYCLES  (DEB),
      .LONG_PRESS_CYCLES(LONG),
      .REPEAT_CYCLES    (REP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .btn_n        (btn_n),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .press_count  (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      cmp_cnt++;
      if (act != exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0d want %0d (edge %0d)",
                  name, act, exp, ecnt);
      end
   endtask

   task automatic m_reset();
      m_s1 = 1; m_s2 = 1;
      m_level = 0; m_run = 0; m_hold = 0;
      m_fired = 0; m_rep = 0; m_count = 0;
      m_press = 0; m_rel = 0; m_long = 0;
   endtask

   task automatic m_step(input int s);
      m_press = 0; m_rel = 0; m_long = 0;
      if (m_level == 0) begin
         if (s == 0) begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_press = 1; m_level = 1; m_run = 0;
               m_hold = 0; m_fired = 0; m_rep = 0;
               m_count = (m_count + 1) % 256;
            end
         end else begin
            m_run = 0;
         end
      end else if (s == 1) begin
         m_run++;
         if (m_run == DEB + 1) begin
            m_rel = 1; m_level = 0; m_run = 0;
         end
      end else if (m_run > 0) begin
         m_run = 0;
      end else if (m_fired == 0) begin
         if (m_hold == LONG - 1) begin
            m_long = 1; m_fired = 1; m_rep = 0;
         end else begin
            m_hold++;
         end
      end else begin
`ifdef BUTTON_READER_REPEAT_EN
         if (m_rep == REP - 1) begin
            m_rep = 0; m_press = 1;
            m_count = (m_count + 1) % 256;
         end else begin
            m_rep++;
         end
`endif
      end
   endtask

   // Model update at each edge, then compare just after it.
   always @(posedge clk) begin
      int s;
      ecnt++;
      if (!reset_n) begin
         m_reset();
      end else begin
         s = m_s2;
         m_s2 = m_s1;
         m_s1 = int'(btn_n);
         m_step(s);
      end
      #1;
      check("btn_level", int'(btn_level), m_level);
      check("press_pulse", int'(press_pulse), m_press);
      check("release_pulse", int'(release_pulse), m_rel);
      check("long_pulse", int'(long_pulse), m_long);
      check("press_count", int'(press_count), m_count);
      if (press_pulse === 1'b1) press_q.push_back(ecnt);
      if (release_pulse === 1'b1) rel_q.push_back(ecnt);
      if (long_pulse === 1'b1) long_q.push_back(ecnt);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_q();
      press_q.delete();
      rel_q.delete();
      long_q.delete();
   endtask

   initial begin
      int t0;
      int c0;
      int exp_press;
      cmp_cnt = 0;
      bad_cnt = 0;
      ecnt = 0;
      m_reset();
      reset_n = 1'b0;
      btn_n = 1'b1;
      cyc(3);
      check("reset_level", int'(btn_level), 0);
      check("reset_count", int'(press_count), 0);
      check("reset_pulses",
            int'({press_pulse, release_pulse, long_pulse}), 0);
      reset_n = 1'b1;
      cyc(3);

      // Clean press: low 10, then release.
      clear_q();
      t0 = ecnt + 1;
      btn_n = 1'b0;
      cyc(10);
      btn_n = 1'b1;
      cyc(15);
      check("clean_npress", press_q.size(), 1);
      check("clean_nrel", rel_q.size(), 1);
      if (press_q.size() > 0)
         check("clean_press_edge", press_q[0] - t0 + 1, 7);
      if (rel_q.size() > 0)
         check("clean_rel_edge", rel_q[0] - (t0 + 10) + 1, 7);
      check("clean_count", int'(press_count), 1);

      // Bounce: low 2, high 1, low 2, high.
      clear_q();
      btn_n = 1'b0; cyc(2);
      btn_n = 1'b1; cyc(1);
      btn_n = 1'b0; cyc(2);
      btn_n = 1'b1; cyc(12);
      check("bounce_npress", press_q.size(), 0);
      check("bounce_nrel", rel_q.size(), 0);
      check("bounce_level", int'(btn_level), 0);
      check("bounce_count", int'(press_count), 1);

      // Long press: low 30.
      clear_q();
      t0 = ecnt + 1;
      btn_n = 1'b0;
      cyc(30);
      btn_n = 1'b1;
      cyc(15);
`ifdef BUTTON_READER_REPEAT_EN
      exp_press = 2;
`else
      exp_press = 1;
`endif
      check("long_npress", press_q.size(), exp_press);
      check("long_nlong", long_q.size(), 1);
      check("long_nrel", rel_q.size(), 1);
      if (press_q.size() > 0) begin
         check("long_press_edge", press_q[0] - t0 + 1, 7);
         if (long_q.size() > 0)
            check("long_delay", long_q[0] - press_q[0], 16);
      end
      if (press_q.size() > 1 && long_q.size() > 0)
         check("repeat_delay", press_q[1] - long_q[0], 8);
      check("long_count", int'(press_count), 1 + exp_press);

      // Release glitch: hold time must resume after the glitch.
      clear_q();
      t0 = ecnt + 1;
      btn_n = 1'b0; cyc(12);
      btn_n = 1'b1; cyc(2);
      btn_n = 1'b0; cyc(14);
      btn_n = 1'b1; cyc(15);
      check("glitch_npress", press_q.size(), 1);
      check("glitch_nrel", rel_q.size(), 1);
      check("glitch_nlong", long_q.size(), 1);
      if (long_q.size() > 0)
         check("glitch_long_edge", long_q[0] - t0 + 1, 26);
      if (rel_q.size() > 0)
         check("glitch_rel_edge", rel_q[0] - (t0 + 28) + 1, 7);

      // Wrap: 256 clean presses bring the count back around.
      c0 = int'(press_count);
      clear_q();
      for (int i = 0; i < 256; i++) begin
         btn_n = 1'b0; cyc(8);
         btn_n = 1'b1; cyc(10);
      end
      check("wrap_npress", press_q.size(), 256);
      check("wrap_count", int'(press_count), c0);

      // Reset during DEB_PRESS with the button held.
      clear_q();
      btn_n = 1'b0;
      cyc(4);
      reset_n = 1'b0;
      cyc(1);
      check("rst_count", int'(press_count), 0);
      check("rst_level", int'(btn_level), 0);
      reset_n = 1'b1;
      t0 = ecnt + 1;
      cyc(12);
      btn_n = 1'b1;
      cyc(15);
      check("rst_npress", press_q.size(), 1);
      if (press_q.size() > 0)
         check("rst_press_edge", press_q[0] - t0 + 1, 7);
      check("rst_final_count", int'(press_count), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240_000; the input must stay stable for this many clk cycles (10 ms at 24 MHz) before a change is accepted; legal range 2..2^25-1.
REQ-002 Parameter LONG_PRESS_CYCLES, default 24_000_000; hold time (1 s at 24 MHz), counted from the accepted press, that qualifies a press as long; must be greater than DEBOUNCE_CYCLES and at most 2^25-1.
REQ-003 Parameter REPEAT_CYCLES, default 6_000_000; auto-repeat period (250 ms); used only under BUTTON_READER_REPEAT_EN.
REQ-004 clk  input  1  single 24 MHz system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 btn_n  input  1  raw push-button pin, active-low, asynchronous to clk, bouncy.
REQ-007 btn_level  output  1  debounced state; 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe when a press is accepted.
REQ-009 release_pulse  output  1  one-cycle strobe when a release is accepted.
REQ-010 long_pulse  output  1  one-cycle strobe when a held press reaches LONG_PRESS_CYCLES.
REQ-011 press_count  output  8  count of accepted presses; wraps from 255 to 0.

Function
REQ-012 btn_n SHALL pass through a two-flop synchronizer (sync_n); no other logic samples btn_n directly.
REQ-013 FSM states: IDLE, DEB_PRESS, PRESSED, HELD, DEB_RELEASE; a 25-bit debounce counter deb_cnt and a 25-bit hold counter hold_cnt.
REQ-014 IDLE: on sync_n=0, go to DEB_PRESS with deb_cnt=0.
REQ-015 DEB_PRESS: on sync_n=1, return to IDLE with no output pulse (bounce rejected); otherwise deb_cnt increments; when deb_cnt=DEBOUNCE_CYCLES-1, go to PRESSED, assert press_pulse, set btn_level=1, clear hold_cnt, increment press_count.
REQ-016 Latency: press_pulse SHALL be high for exactly one cycle, starting DEBOUNCE_CYCLES+3 rising edges after the first edge that samples btn_n=0, given a clean low.
REQ-017 PRESSED: hold_cnt increments each cycle; when hold_cnt=LONG_PRESS_CYCLES-1, go to HELD and assert long_pulse for one cycle.
REQ-018 PRESSED or HELD: on sync_n=1, go to DEB_RELEASE with deb_cnt=0; hold_cnt freezes.
REQ-019 DEB_RELEASE: on sync_n=0, return to HELD if long_pulse has already fired for this press, otherwise to PRESSED; hold_cnt resumes from its frozen value and no pulse is issued. When deb_cnt=DEBOUNCE_CYCLES-1 with sync_n=1, go to IDLE, assert release_pulse, and set btn_level=0.
REQ-020 Simultaneous events: release detection (REQ-018) takes priority over a long or repeat threshold reached in the same cycle; that threshold pulse is not issued.
REQ-021 press_pulse, release_pulse and long_pulse are mutually exclusive in any cycle; all outputs are registered.
REQ-022 btn_level SHALL change only on accepted transitions; it never toggles during DEB_PRESS or DEB_RELEASE.

Reset
REQ-023 When reset_n=0 at a rising edge: state=IDLE; both synchronizer flops=1; deb_cnt=0; hold_cnt=0; btn_level=0; press_pulse, release_pulse and long_pulse all 0; press_count=0.
REQ-024 Reset mid-operation aborts any debounce or hold with no pulse; if the button is still held after reset, it is debounced afresh and produces a new press_pulse.

Configuration
REQ-025 Macro BUTTON_READER_REPEAT_EN defined: in HELD, press_pulse re-asserts for one cycle, and press_count increments, every REPEAT_CYCLES cycles after long_pulse while the button stays held; the repeat counter freezes in DEB_RELEASE.
REQ-026 Macro not defined: HELD issues no further pulses; the REPEAT_CYCLES parameter is accepted but unused, and no repeat logic is synthesized.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, REPEAT_CYCLES=8)
REQ-027 Clean press: btn_n low for 10 cycles, then high -> press_pulse at edge 7; press_count=1; btn_level=1 until release_pulse, 7 edges after the rise.
REQ-028 Bounce: btn_n low 2 cycles, high 1, low 2, high -> no pulses; btn_level stays 0; press_count stays 0.
REQ-029 Long press: btn_n held low for 30 cycles -> exactly one press_pulse, then long_pulse 16 cycles later; with BUTTON_READER_REPEAT_EN, a further press_pulse every 8 cycles and press_count incremented for each.
REQ-030 Release glitch: while in PRESSED, btn_n high for 2 cycles -> no release_pulse; state returns to PRESSED and hold_cnt resumes.
REQ-031 Wrap: 256 clean presses -> press_count returns to 0.
REQ-032 Reset: reset_n low for 1 cycle during DEB_PRESS with btn_n held low -> all outputs 0; press_pulse occurs DEBOUNCE_CYCLES+3 edges after reset_n returns high.
